// File: rtl/fp_taylor_cos_seq_pkg.sv
// Shared definitions for the sequential Taylor-series cosine evaluator:
// FSM state encoding, term count and coefficient-index width.
package fp_taylor_cos_seq_pkg;

    localparam int TERM_CNT = 4;
    localparam int IDX_W    = 2;
    localparam int DATA_W   = 32;

    // Highest coefficient index seeds the accumulator; the next one is the first add.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TERM_CNT - 1);
    localparam logic [IDX_W-1:0] FIRST_K  = IDX_W'(TERM_CNT - 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQ_REQ,
        ST_SQ_WAIT,
        ST_MUL_REQ,
        ST_MUL_WAIT,
        ST_ADD_REQ,
        ST_ADD_WAIT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fp_taylor_cos_fsm.sv
// Control FSM for the Horner cosine: square, three multiply/add rounds, result hand-off.
// Latency: one state per step plus unit latency; requests hold until ready, result holds until out_ready.
module fp_taylor_cos_fsm
    import fp_taylor_cos_seq_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   in_valid_i,
    input  logic   out_ready_i,
    input  logic   mul_req_ready_i,
    input  logic   add_req_ready_i,
    input  logic   mul_rsp_i,
    input  logic   add_rsp_i,
    input  logic   k_zero_i,
    output state_e state_o,
    output logic   in_ready_o,
    output logic   out_valid_o,
    output logic   mul_req_valid_o,
    output logic   add_req_valid_o
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        in_ready_o      = 1'b0;
        out_valid_o     = 1'b0;
        mul_req_valid_o = 1'b0;
        add_req_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_o = ~rst_i;
                if (in_valid_i) state_d = ST_SQ_REQ;
            end
            ST_SQ_REQ: begin
                mul_req_valid_o = 1'b1;
                if (mul_req_ready_i) state_d = ST_SQ_WAIT;
            end
            ST_SQ_WAIT: begin
                if (mul_rsp_i) state_d = ST_MUL_REQ;
            end
            ST_MUL_REQ: begin
                mul_req_valid_o = 1'b1;
                if (mul_req_ready_i) state_d = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (mul_rsp_i) state_d = ST_ADD_REQ;
            end
            ST_ADD_REQ: begin
                add_req_valid_o = 1'b1;
                if (add_req_ready_i) state_d = ST_ADD_WAIT;
            end
            ST_ADD_WAIT: begin
                if (add_rsp_i) state_d = k_zero_i ? ST_DONE : ST_MUL_REQ;
            end
            ST_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/fp_taylor_cos_seq.sv
// Sequential cos(x) via Horner c0 + x2*(c1 + x2*(c2 + x2*c3)) using external FP multiplier/adder.
// Latency: ~9 states plus 7 unit round-trips; in_ready only in IDLE, result held until out_ready.
module fp_taylor_cos_seq
    import fp_taylor_cos_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [IDX_W-1:0]  lut_base,
    input  logic [DATA_W-1:0] lut_coeff,
    output logic              mul_req_valid,
    input  logic              mul_req_ready,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic              mul_resp_valid,
    input  logic [DATA_W-1:0] mul_result,
    output logic              add_req_valid,
    input  logic              add_req_ready,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    input  logic              add_resp_valid,
    input  logic [DATA_W-1:0] add_result
);

    state_e state;

    logic [DATA_W-1:0] x_q,   x_d;
    logic [DATA_W-1:0] x2_q,  x2_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] prod_q, prod_d;
    logic [IDX_W-1:0]  k_q,   k_d;
    logic              mul_pend_q, mul_pend_d;
    logic [DATA_W-1:0] mul_pend_dat_q, mul_pend_dat_d;
    logic              add_pend_q, add_pend_d;
    logic [DATA_W-1:0] add_pend_dat_q, add_pend_dat_d;

    logic              mul_wait, add_wait;
    logic              mul_rsp_hit, add_rsp_hit;
    logic [DATA_W-1:0] mul_rsp_dat, add_rsp_dat;
    logic              mul_hs, add_hs;

    // A response coinciding with its request handshake is parked and consumed in the WAIT state.
    assign mul_wait    = (state == ST_SQ_WAIT) || (state == ST_MUL_WAIT);
    assign add_wait    = (state == ST_ADD_WAIT);
    assign mul_hs      = mul_req_valid && mul_req_ready;
    assign add_hs      = add_req_valid && add_req_ready;
    assign mul_rsp_hit = mul_wait && (mul_resp_valid || mul_pend_q);
    assign add_rsp_hit = add_wait && (add_resp_valid || add_pend_q);
    assign mul_rsp_dat = mul_pend_q ? mul_pend_dat_q : mul_result;
    assign add_rsp_dat = add_pend_q ? add_pend_dat_q : add_result;

    fp_taylor_cos_fsm u_fsm (
        .clk_i           (clk),
        .rst_i           (rst),
        .in_valid_i      (in_valid),
        .out_ready_i     (out_ready),
        .mul_req_ready_i (mul_req_ready),
        .add_req_ready_i (add_req_ready),
        .mul_rsp_i       (mul_rsp_hit),
        .add_rsp_i       (add_rsp_hit),
        .k_zero_i        (k_q == '0),
        .state_o         (state),
        .in_ready_o      (in_ready),
        .out_valid_o     (out_valid),
        .mul_req_valid_o (mul_req_valid),
        .add_req_valid_o (add_req_valid)
    );

    // Operands are steered from registers only, so they stay frozen while a request stalls.
    always_comb begin
        lut_base   = '0;
        mul_a      = '0;
        mul_b      = '0;
        add_a      = '0;
        add_b      = '0;
        out_result = '0;
        case (state)
            ST_SQ_REQ: begin
                lut_base = LAST_IDX;
                mul_a    = x_q;
                mul_b    = x_q;
            end
            ST_SQ_WAIT: lut_base = LAST_IDX;
            ST_MUL_REQ: begin
                lut_base = k_q;
                mul_a    = acc_q;
                mul_b    = x2_q;
            end
            ST_MUL_WAIT, ST_ADD_WAIT: lut_base = k_q;
            ST_ADD_REQ: begin
                lut_base = k_q;
                add_a    = prod_q;
                add_b    = lut_coeff;
            end
            ST_DONE: out_result = acc_q;
            default: ;
        endcase
    end

    always_comb begin
        x_d            = x_q;
        x2_d           = x2_q;
        acc_d          = acc_q;
        prod_d         = prod_q;
        k_d            = k_q;
        mul_pend_d     = mul_pend_q;
        mul_pend_dat_d = mul_pend_dat_q;
        add_pend_d     = add_pend_q;
        add_pend_dat_d = add_pend_dat_q;

        if (mul_hs && mul_resp_valid) begin
            mul_pend_d     = 1'b1;
            mul_pend_dat_d = mul_result;
        end else if (mul_rsp_hit) begin
            mul_pend_d = 1'b0;
        end
        if (add_hs && add_resp_valid) begin
            add_pend_d     = 1'b1;
            add_pend_dat_d = add_result;
        end else if (add_rsp_hit) begin
            add_pend_d = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) x_d = in_x;
            end
            ST_SQ_WAIT: begin
                if (mul_rsp_hit) begin
                    x2_d  = mul_rsp_dat;
                    acc_d = lut_coeff;
                    k_d   = FIRST_K;
                end
            end
            ST_MUL_WAIT: begin
                if (mul_rsp_hit) prod_d = mul_rsp_dat;
            end
            ST_ADD_WAIT: begin
                if (add_rsp_hit) begin
                    acc_d = add_rsp_dat;
                    if (k_q != '0) k_d = k_q - IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q            <= '0;
            x2_q           <= '0;
            acc_q          <= '0;
            prod_q         <= '0;
            k_q            <= '0;
            mul_pend_q     <= 1'b0;
            mul_pend_dat_q <= '0;
            add_pend_q     <= 1'b0;
            add_pend_dat_q <= '0;
        end else begin
            x_q            <= x_d;
            x2_q           <= x2_d;
            acc_q          <= acc_d;
            prod_q         <= prod_d;
            k_q            <= k_d;
            mul_pend_q     <= mul_pend_d;
            mul_pend_dat_q <= mul_pend_dat_d;
            add_pend_q     <= add_pend_d;
            add_pend_dat_q <= add_pend_dat_d;
        end
    end

endmodule

// File: tb/tb_fp_taylor_cos_seq.sv
// Bench for fp_taylor_cos_seq: behavioural FP units and LUT, Horner reference model.
module tb_fp_taylor_cos_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [1:0]  lut_base;
    logic [31:0] lut_coeff;
    logic        mul_req_valid;
    logic        mul_req_ready = 1'b0;
    logic [31:0] mul_a, mul_b;
    logic        mul_resp_valid = 1'b0;
    logic [31:0] mul_result = '0;
    logic        add_req_valid;
    logic        add_req_ready = 1'b0;
    logic [31:0] add_a, add_b;
    logic        add_resp_valid = 1'b0;
    logic [31:0] add_result = '0;

    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;
    int mul_hs = 0;
    int add_hs = 0;
    int add_rsp_pulses = 0;
    int mul_lat_max = 1;
    int add_lat_max = 1;
    int add_lat_force = 0;
    bit rand_rdy = 1'b0;
    bit stall_arm = 1'b0;
    int stall_left = 0;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } rsp_t;
    rsp_t mq[$];
    rsp_t aq[$];

    always #5 clk = ~clk;

    fp_taylor_cos_seq dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_x           (in_x),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .lut_base       (lut_base),
        .lut_coeff      (lut_coeff),
        .mul_req_valid  (mul_req_valid),
        .mul_req_ready  (mul_req_ready),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_resp_valid (mul_resp_valid),
        .mul_result     (mul_result),
        .add_req_valid  (add_req_valid),
        .add_req_ready  (add_req_ready),
        .add_a          (add_a),
        .add_b          (add_b),
        .add_resp_valid (add_resp_valid),
        .add_result     (add_result)
    );

    // Inverse-factorial coefficients: 1, -1/2!, 1/4!, -1/6!
    function automatic logic [31:0] coef(input logic [1:0] k);
        case (k)
            2'd0:    return 32'h3f800000;
            2'd1:    return 32'hbf000000;
            2'd2:    return 32'h3d2aaaab;
            default: return 32'hbab60b61;
        endcase
    endfunction

    assign lut_coeff = coef(lut_base);

    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) begin
            d = {b[31], 63'd0};
        end else begin
            d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int          e;
        logic [30:0] body;
        logic        rnd;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e    = int'(d[62:52]) - 1023 + 127;
        body = {e[7:0], d[51:29]};
        rnd  = d[28] && ((d[27:0] != 28'd0) || d[29]);
        return {d[63], body + 31'(rnd)};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) * sp2r(b));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) + sp2r(b));
    endfunction

    function automatic logic [31:0] ref_cos(input logic [31:0] x);
        logic [31:0] x2;
        logic [31:0] acc;
        x2  = fmul(x, x);
        acc = coef(2'd3);
        for (int k = 2; k >= 0; k--) acc = fadd(fmul(acc, x2), coef(2'(k)));
        return acc;
    endfunction

    function automatic logic [31:0] rand_x();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(1, 0));
        v[30:23] = 8'($urandom_range(127, 118));
        v[22:0]  = 23'($urandom());
        return v;
    endfunction

    function automatic int lat(input int mx);
        return (mx <= 1) ? 1 : int'($urandom_range(mx, 1));
    endfunction

    function automatic logic [31:0] ulp_dist(input logic [31:0] a, input logic [31:0] b);
        int dd;
        dd = int'(a) - int'(b);
        if (dd < 0) dd = -dd;
        return 32'(dd);
    endfunction

    // External multiplier and adder: sample handshakes mid-cycle, answer after a latency >= 1.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            cyc++;
            mul_resp_valid = 1'b0;
            add_resp_valid = 1'b0;
            if (mq.size() > 0 && mq[0].due == cyc) begin
                mul_resp_valid = 1'b1;
                mul_result     = mq[0].dat;
                void'(mq.pop_front());
            end
            if (aq.size() > 0 && aq[0].due == cyc) begin
                add_resp_valid = 1'b1;
                add_result     = aq[0].dat;
                add_rsp_pulses++;
                void'(aq.pop_front());
            end
            if (stall_left > 0) begin
                mul_req_ready = 1'b0;
                stall_left--;
            end else if (stall_arm && mul_req_valid && mul_hs == 1) begin
                mul_req_ready = 1'b0;
                stall_left    = 4;
                stall_arm     = 1'b0;
            end else begin
                mul_req_ready = rand_rdy ? ($urandom_range(3, 0) != 0) : 1'b1;
            end
            add_req_ready = rand_rdy ? ($urandom_range(3, 0) != 0) : 1'b1;
            #1;
            if (mul_req_valid && mul_req_ready && !rst) begin
                mul_hs++;
                r.due = cyc + lat(mul_lat_max);
                r.dat = fmul(mul_a, mul_b);
                mq.push_back(r);
            end
            if (add_req_valid && add_req_ready && !rst) begin
                add_hs++;
                r.due = cyc + ((add_lat_force > 0) ? add_lat_force : lat(add_lat_max));
                r.dat = fadd(add_a, add_b);
                aq.push_back(r);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic start_op(input logic [31:0] x);
        int n;
        mul_hs   = 0;
        add_hs   = 0;
        in_x     = x;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_x     = $urandom();
    endtask

    task automatic finish_op(input int hold, output logic [31:0] res);
        int n;
        n = 0;
        while (!out_valid && n < 3000) begin
            tick();
            n++;
        end
        check("out_wait", 32'(out_valid), 32'd1);
        res = out_result;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", out_result, res);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] res;
        logic [31:0] a0;
        int          n;
        int          p0;

        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mul_valid", 32'(mul_req_valid), 32'd0);
        check("rst_add_valid", 32'(add_req_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_mul_a", mul_a, 32'd0);
        check("rst_mul_b", mul_b, 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_add_b", add_b, 32'd0);
        check("rst_lut_base", 32'(lut_base), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // x = 0 with ideal single-cycle units
        start_op(32'h00000000);
        finish_op(0, res);
        check("zero_result", res, 32'h3f800000);
        check("zero_mul_hs", 32'(mul_hs), 32'd4);
        check("zero_add_hs", 32'(add_hs), 32'd3);

        start_op(32'h3f800000);
        finish_op(0, res);
        check("pos1_model", res, ref_cos(32'h3f800000));
        check("pos1_ulp_ok", 32'(ulp_dist(res, 32'h3f0a4fa4) <= 32'd2), 32'd1);

        start_op(32'hbf800000);
        finish_op(0, res);
        check("neg1_model", res, ref_cos(32'hbf800000));
        check("neg1_ulp_ok", 32'(ulp_dist(res, 32'h3f0a4fa4) <= 32'd2), 32'd1);

        // Second multiply stalled for five cycles
        x = rand_x();
        stall_arm = 1'b1;
        start_op(x);
        n = 0;
        while (!(mul_req_valid && mul_hs == 1 && !mul_req_ready) && n < 100) begin
            tick();
            n++;
        end
        check("stall_seen", 32'(mul_req_ready), 32'd0);
        check("stall_a_acc", mul_a, coef(2'd3));
        check("stall_b_x2", mul_b, fmul(x, x));
        a0 = mul_a;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("stall_a", mul_a, a0);
            check("stall_b", mul_b, fmul(x, x));
            check("stall_valid", 32'(mul_req_valid), 32'd1);
        end
        finish_op(0, res);
        check("stall_result", res, ref_cos(x));
        check("stall_mul_hs", 32'(mul_hs), 32'd4);

        // Output held off for ten cycles
        x = rand_x();
        start_op(x);
        finish_op(10, res);
        check("hold_final", res, ref_cos(x));

        // Randomised latency and ready
        rand_rdy    = 1'b1;
        mul_lat_max = 3;
        add_lat_max = 3;
        for (int i = 0; i < 8; i++) begin
            x = rand_x();
            start_op(x);
            finish_op(int'($urandom_range(2, 0)), res);
            check("rand_result", res, ref_cos(x));
            check("rand_mul_hs", 32'(mul_hs), 32'd4);
            check("rand_add_hs", 32'(add_hs), 32'd3);
        end
        rand_rdy    = 1'b0;
        mul_lat_max = 1;
        add_lat_max = 1;

        // Reset during ADD_WAIT with k=1, then a late adder response
        add_lat_force = 5;
        x = rand_x();
        start_op(x);
        n = 0;
        while (add_hs < 2 && n < 200) begin
            tick();
            n++;
        end
        check("mid_add_k1", 32'(lut_base), 32'd1);
        tick();
        check("mid_wait_add_valid", 32'(add_req_valid), 32'd0);
        check("mid_wait_k1", 32'(lut_base), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_add_valid", 32'(add_req_valid), 32'd0);
        check("arst_mul_valid", 32'(mul_req_valid), 32'd0);
        check("arst_lut_base", 32'(lut_base), 32'd0);
        tick();
        rst = 1'b0;
        p0 = add_rsp_pulses;
        n = 0;
        while (add_rsp_pulses == p0 && n < 20) begin
            tick();
            n++;
        end
        check("late_rsp_seen", 32'(add_rsp_pulses - p0), 32'd1);
        add_lat_force = 0;
        tick();
        check("late_in_ready", 32'(in_ready), 32'd1);
        check("late_out_valid", 32'(out_valid), 32'd0);
        check("late_mul_valid", 32'(mul_req_valid), 32'd0);
        check("late_add_valid", 32'(add_req_valid), 32'd0);
        check("late_lut_base", 32'(lut_base), 32'd0);

        x = rand_x();
        start_op(x);
        finish_op(0, res);
        check("after_rst_result", res, ref_cos(x));
        check("after_rst_mul_hs", 32'(mul_hs), 32'd4);
        check("after_rst_add_hs", 32'(add_hs), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_taylor_cos_seq.md
FP_TAYLOR_COS_SEQ -- requirements
Module: fp_taylor_cos_seq

Interface
REQ-001 Parameters: none; term count fixed at 4 (coefficient indices 0..3) and data width fixed at 32 (IEEE-754 single).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid / in_ready / in_x  in/out/in  1/1/32  operand x; transfers when both valid and ready are high.
REQ-005 out_valid / out_ready / out_result  out/in/out  1/1/32  cos(x) approximation; transfers when both are high.
REQ-006 lut_base  out  2  coefficient index to the inverse-factorial LUT.
REQ-007 lut_coeff  in  32  signed coefficient from that LUT, combinational from lut_base: 1, -1/2!, 1/4!, -1/6!.
REQ-008 mul_req_valid, mul_req_ready, mul_a[31:0], mul_b[31:0], mul_resp_valid, mul_result[31:0]  to/from an external FP multiplier.
REQ-009 add_req_valid, add_req_ready, add_a[31:0], add_b[31:0], add_resp_valid, add_result[31:0]  to/from an external FP adder.

Function
REQ-010 Computes the Horner form c0 + x2*(c1 + x2*(c2 + x2*c3)) with x2 = x*x and ck = lut_coeff at lut_base=k.
REQ-011 FSM states: IDLE, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, DONE.
REQ-012 IDLE: in_ready=1 only here. On an input handshake, register x and go to SQ_REQ.
REQ-013 SQ_REQ: drive mul_a=mul_b=x with mul_req_valid=1. On mul_req_ready, go to SQ_WAIT.
REQ-014 SQ_WAIT: on mul_resp_valid, store x2, load acc=lut_coeff with lut_base=3, set k=2, and go to MUL_REQ.
REQ-015 MUL_REQ: drive mul_a=acc, mul_b=x2. On handshake, go to MUL_WAIT; on response, store the product and go to ADD_REQ.
REQ-016 ADD_REQ: drive add_a=product, add_b=lut_coeff with lut_base=k. On handshake, go to ADD_WAIT; on response, acc=add_result.
REQ-017 After the ADD_WAIT response: if k=0 go to DONE; otherwise decrement k and go to MUL_REQ.
REQ-018 DONE: out_valid=1 and out_result=acc, both held stable until out_ready; then go to IDLE, with in_ready=1 in the following cycle (no same-cycle re-accept).
REQ-019 While a request valid is high and ready is low, operands and valid are held unchanged; valid is never withdrawn before its handshake.
REQ-020 Exactly one request per state visit; the block issues 4 multiplies and 3 adds per operand.
REQ-021 *_resp_valid is a one-cycle pulse with no backpressure. A response arriving outside the matching WAIT state is ignored. A response in the same cycle as its request handshake is accepted in the WAIT state the following cycle; the external units guarantee a response of at least 1 cycle after the request.
REQ-022 lut_base is 0 in IDLE and DONE, and equals the active index otherwise.
REQ-023 No arithmetic is performed internally: operands pass through bit-exactly, and NaN/Inf/denormal handling belongs to the external units.

Reset
REQ-024 rst forces IDLE asynchronously, from any state including mid-operation, and discards any pending request or response.
REQ-025 Reset values: in_ready=0 while rst is high, then 1; out_valid=0; mul_req_valid=0; add_req_valid=0; out_result, mul_a/b and add_a/b = 32'h0; lut_base=0; k=0.

Structure
REQ-026 A shared taylor package holds the FSM state enum, the term-count constant (4), and the coefficient-index width (2).
REQ-027 The coefficient LUT is instantiated outside this block and is fed through the lut_base/lut_coeff ports. The natural single sub-module is fp_taylor_cos_fsm (next-state plus request-valid logic); the datapath registers stay in the top.

Verification
REQ-028 x=32'h00000000, ideal 1-cycle units -> out_result=32'h3f800000, with 4 multiply and 3 add handshakes.
REQ-029 x=32'h3f800000 (1.0) and x=32'hbf800000 (-1.0) -> both results within 2 ulp of 32'h3f0a4fa4 (0.5402778).
REQ-030 mul_req_ready held low for 5 cycles during the second multiply -> mul_a, mul_b and mul_req_valid stay constant; final result unchanged.
REQ-031 out_ready held low for 10 cycles -> out_valid and out_result stay stable, in_ready=0 throughout; in_ready=1 the cycle after the handshake.
REQ-032 rst pulsed during ADD_WAIT with k=1, then a late add_resp_valid arrives -> block in IDLE, all valids 0, late response ignored, next operand computes correctly.
